// File: rtl/wb_lsu_master.sv
// rtl/wb_lsu_master.sv - RV32I load/store unit driving a Wishbone classic data bus
module wb_lsu_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_misaligned,
    output logic [31:0] dwb_adr_o,
    output logic [31:0] dwb_dat_o,
    output logic        dwb_we_o,
    output logic [3:0]  dwb_sel_o,
    output logic        dwb_cyc_o,
    output logic        dwb_stb_o,
    input  logic [31:0] dwb_dat_i,
    input  logic        dwb_ack_i,
    input  logic        dwb_err_i
);
    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t      state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [2:0]  f3, f3_n;
    logic [1:0]  off, off_n;
    logic        req_ready_n, rsp_valid_n, rsp_err_n, rsp_mis_n;
    logic [31:0] rsp_rdata_n, adr_n, dat_n;
    logic        we_n, cyc_n;
    logic [3:0]  sel_n;

    logic        illegal, misaligned;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    always_comb begin
        illegal = req_we ? (req_funct3 > 3'b010)
                         : (req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111);
        misaligned = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                     (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
    end

    // Lane selection uses the offset latched at accept, not the live request.
    always_comb begin
        ld_byte = 8'(dwb_dat_i >> {off, 3'b000});
        ld_half = off[1] ? dwb_dat_i[31:16] : dwb_dat_i[15:0];
        case (f3)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'h0, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_data = {16'h0, ld_half};
            default: ld_data = dwb_dat_i;
        endcase
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        f3_n        = f3;
        off_n       = off;
        req_ready_n = req_ready;
        rsp_valid_n = 1'b0;
        rsp_err_n   = 1'b0;
        rsp_mis_n   = 1'b0;
        rsp_rdata_n = 32'h0;
        adr_n       = dwb_adr_o;
        dat_n       = dwb_dat_o;
        we_n        = dwb_we_o;
        sel_n       = dwb_sel_o;
        cyc_n       = dwb_cyc_o;
        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    f3_n        = req_funct3;
                    off_n       = req_addr[1:0];
                    req_ready_n = 1'b0;
                    if (illegal) begin
                        state_n     = RESP;
                        rsp_valid_n = 1'b1;
                        rsp_err_n   = 1'b1;
                    end else if (misaligned) begin
                        state_n     = RESP;
                        rsp_valid_n = 1'b1;
                        rsp_mis_n   = 1'b1;
                    end else begin
                        state_n = BUS;
                        cnt_n   = 16'h0;
                        cyc_n   = 1'b1;
                        adr_n   = {req_addr[31:2], 2'b00};
                        we_n    = req_we;
                        case (req_funct3[1:0])
                            2'b00:   sel_n = 4'b0001 << req_addr[1:0];
                            2'b01:   sel_n = 4'b0011 << {req_addr[1], 1'b0};
                            default: sel_n = 4'b1111;
                        endcase
                        if (!req_we)
                            dat_n = 32'h0;
                        else if (req_funct3[1:0] == 2'b00)
                            dat_n = {4{req_wdata[7:0]}};
                        else if (req_funct3[1:0] == 2'b01)
                            dat_n = {2{req_wdata[15:0]}};
                        else
                            dat_n = req_wdata;
                    end
                end
            end
            BUS: begin
                if (dwb_ack_i || dwb_err_i || cnt == 16'(TIMEOUT_CYCLES - 1)) begin
                    state_n     = RESP;
                    rsp_valid_n = 1'b1;
                    cyc_n       = 1'b0;
                    adr_n       = 32'h0;
                    dat_n       = 32'h0;
                    we_n        = 1'b0;
                    sel_n       = 4'h0;
                    // err outranks ack; a plain timeout also reports err.
                    if (dwb_err_i || !dwb_ack_i)
                        rsp_err_n = 1'b1;
                    else if (!dwb_we_o)
                        rsp_rdata_n = ld_data;
                end else begin
                    cnt_n = cnt + 16'h1;
                end
            end
            RESP: begin
                state_n     = IDLE;
                req_ready_n = 1'b1;
            end
            default: begin
                state_n     = IDLE;
                req_ready_n = 1'b1;
                cyc_n       = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= 16'h0;
            f3             <= 3'h0;
            off            <= 2'h0;
            req_ready      <= 1'b1;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= 32'h0;
            rsp_err        <= 1'b0;
            rsp_misaligned <= 1'b0;
            dwb_adr_o      <= 32'h0;
            dwb_dat_o      <= 32'h0;
            dwb_we_o       <= 1'b0;
            dwb_sel_o      <= 4'h0;
            dwb_cyc_o      <= 1'b0;
            dwb_stb_o      <= 1'b0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            f3             <= f3_n;
            off            <= off_n;
            req_ready      <= req_ready_n;
            rsp_valid      <= rsp_valid_n;
            rsp_rdata      <= rsp_rdata_n;
            rsp_err        <= rsp_err_n;
            rsp_misaligned <= rsp_mis_n;
            dwb_adr_o      <= adr_n;
            dwb_dat_o      <= dat_n;
            dwb_we_o       <= we_n;
            dwb_sel_o      <= sel_n;
            dwb_cyc_o      <= cyc_n;
            dwb_stb_o      <= cyc_n;
        end
    end
endmodule

// File: tb/tb_wb_lsu_master.sv
// tb/tb_wb_lsu_master.sv - directed self-checking bench for wb_lsu_master
module tb_wb_lsu_master;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err, rsp_misaligned;
    logic [31:0] rsp_rdata;
    logic [31:0] dwb_adr_o, dwb_dat_o, dwb_dat_i;
    logic        dwb_we_o, dwb_cyc_o, dwb_stb_o, dwb_ack_i, dwb_err_i;
    logic [3:0]  dwb_sel_o;

    int checks = 0;
    int fails  = 0;

    localparam logic [31:0] MEM100 = 32'h8234_56F0;

    wb_lsu_master #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_misaligned(rsp_misaligned),
        .dwb_adr_o(dwb_adr_o), .dwb_dat_o(dwb_dat_o), .dwb_we_o(dwb_we_o),
        .dwb_sel_o(dwb_sel_o), .dwb_cyc_o(dwb_cyc_o), .dwb_stb_o(dwb_stb_o),
        .dwb_dat_i(dwb_dat_i), .dwb_ack_i(dwb_ack_i), .dwb_err_i(dwb_err_i)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        tick();
        req_valid  = 1'b0;
    endtask

    // One idle wait cycle, then the responder terminates for one cycle.
    task automatic respond(input logic ack, input logic err, input logic [31:0] data);
        tick();
        dwb_ack_i = ack;
        dwb_err_i = err;
        dwb_dat_i = data;
        tick();
        dwb_ack_i = 1'b0;
        dwb_err_i = 1'b0;
        dwb_dat_i = 32'h0;
    endtask

    task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [3:0] esel, input logic [31:0] erdata);
        do_req(1'b0, f3, addr, 32'hDEAD_BEEF);
        check({tag, " cyc"}, 32'(dwb_cyc_o), 32'd1);
        check({tag, " adr"}, dwb_adr_o, {addr[31:2], 2'b00});
        check({tag, " sel"}, 32'(dwb_sel_o), 32'(esel));
        check({tag, " we"}, 32'(dwb_we_o), 32'd0);
        respond(1'b1, 1'b0, MEM100);
        check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, " rsp_err"}, 32'(rsp_err), 32'd0);
        check({tag, " rdata"}, rsp_rdata, erdata);
        tick();
        check({tag, " idle valid"}, 32'(rsp_valid), 32'd0);
        check({tag, " idle ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'h0; req_addr = 32'h0; req_wdata = 32'h0;
        dwb_dat_i = 32'h0; dwb_ack_i = 1'b0; dwb_err_i = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        check("reset ready", 32'(req_ready), 32'd1);
        check("reset cyc", 32'(dwb_cyc_o), 32'd0);
        check("reset stb", 32'(dwb_stb_o), 32'd0);
        check("reset valid", 32'(rsp_valid), 32'd0);
        check("reset adr", dwb_adr_o, 32'h0);
        check("reset sel", 32'(dwb_sel_o), 32'h0);

        run_load("LB103", 3'b000, 32'h103, 4'b1000, 32'hFFFF_FF82);
        run_load("LBU103", 3'b100, 32'h103, 4'b1000, 32'h0000_0082);
        run_load("LHU102", 3'b101, 32'h102, 4'b1100, 32'h0000_8234);
        run_load("LH102", 3'b001, 32'h102, 4'b1100, 32'hFFFF_8234);
        run_load("LH100", 3'b001, 32'h100, 4'b0011, 32'h0000_56F0);
        run_load("LB100", 3'b000, 32'h100, 4'b0001, 32'hFFFF_FFF0);
        run_load("LBU101", 3'b100, 32'h101, 4'b0010, 32'h0000_0056);
        run_load("LW100", 3'b010, 32'h100, 4'b1111, 32'h8234_56F0);

        do_req(1'b1, 3'b001, 32'h206, 32'h0000_BEEF);
        check("SH adr", dwb_adr_o, 32'h204);
        check("SH sel", 32'(dwb_sel_o), 32'b1100);
        check("SH dat", dwb_dat_o, 32'hBEEF_BEEF);
        check("SH we", 32'(dwb_we_o), 32'd1);
        respond(1'b1, 1'b0, 32'hFFFF_FFFF);
        check("SH valid", 32'(rsp_valid), 32'd1);
        check("SH err", 32'(rsp_err), 32'd0);
        check("SH rdata", rsp_rdata, 32'h0);
        tick();

        do_req(1'b1, 3'b000, 32'h201, 32'h1234_5678);
        check("SB sel", 32'(dwb_sel_o), 32'b0010);
        check("SB dat", dwb_dat_o, 32'h7878_7878);
        respond(1'b1, 1'b0, 32'h0);
        check("SB valid", 32'(rsp_valid), 32'd1);
        tick();

        do_req(1'b0, 3'b010, 32'h102, 32'h0);
        check("LWmis cyc", 32'(dwb_cyc_o), 32'd0);
        check("LWmis valid", 32'(rsp_valid), 32'd1);
        check("LWmis flag", 32'(rsp_misaligned), 32'd1);
        check("LWmis err", 32'(rsp_err), 32'd0);
        tick();
        check("LWmis after cyc", 32'(dwb_cyc_o), 32'd0);
        check("LWmis after flag", 32'(rsp_misaligned), 32'd0);

        do_req(1'b1, 3'b001, 32'h301, 32'h0);
        check("SHmis flag", 32'(rsp_misaligned), 32'd1);
        tick();

        do_req(1'b0, 3'b011, 32'h100, 32'h0);
        check("ill load cyc", 32'(dwb_cyc_o), 32'd0);
        check("ill load valid", 32'(rsp_valid), 32'd1);
        check("ill load err", 32'(rsp_err), 32'd1);
        check("ill load mis", 32'(rsp_misaligned), 32'd0);
        tick();
        do_req(1'b1, 3'b100, 32'h100, 32'h0);
        check("ill store err", 32'(rsp_err), 32'd1);
        tick();

        do_req(1'b0, 3'b010, 32'h500, 32'h0);
        n = 0;
        for (int i = 0; i < 20 && dwb_cyc_o; i++) begin
            n++;
            tick();
        end
        check("timeout cyc cycles", 32'(n), 32'd8);
        check("timeout valid", 32'(rsp_valid), 32'd1);
        check("timeout err", 32'(rsp_err), 32'd1);
        tick();

        do_req(1'b0, 3'b010, 32'h100, 32'h0);
        respond(1'b1, 1'b1, MEM100);
        check("ack+err valid", 32'(rsp_valid), 32'd1);
        check("ack+err err", 32'(rsp_err), 32'd1);
        check("ack+err rdata", rsp_rdata, 32'h0);
        tick();

        do_req(1'b1, 3'b010, 32'h100, 32'h5);
        respond(1'b0, 1'b1, 32'h0);
        check("err err", 32'(rsp_err), 32'd1);
        tick();

        dwb_ack_i = 1'b1;
        tick();
        check("idle ack valid", 32'(rsp_valid), 32'd0);
        dwb_ack_i = 1'b0;

        do_req(1'b1, 3'b010, 32'h600, 32'h9);
        check("pre-rst stb", 32'(dwb_stb_o), 32'd1);
        rst = 1'b1;
        #1;
        check("rst cyc", 32'(dwb_cyc_o), 32'd0);
        check("rst stb", 32'(dwb_stb_o), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("post-rst valid", 32'(rsp_valid), 32'd0);
        check("post-rst ready", 32'(req_ready), 32'd1);

        do_req(1'b1, 3'b010, 32'h400, 32'h1);
        check("SW400 adr", dwb_adr_o, 32'h400);
        check("SW400 sel", 32'(dwb_sel_o), 32'hF);
        check("SW400 dat", dwb_dat_o, 32'h1);
        respond(1'b1, 1'b0, 32'h0);
        check("SW400 valid", 32'(rsp_valid), 32'd1);
        check("SW400 err", 32'(rsp_err), 32'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end
endmodule
